// File: rtl/mult_control.sv
// Sequencing FSM for the 8-bit signed shift-add multiplier: one N-iteration multiply per Run press.
// Optional build macro MULT_CTRL_SKIP_EN folds the shift into ADD when M=0 (skips the SHIFT state).
module mult_control #(
    parameter int N = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clear_A,
    output logic Ld_A,
    output logic Ld_B,
    output logic Shift_En,
    output logic Add,
    output logic Sub,
    output logic Busy,
    output logic Done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_iter;

    assign last_iter = (cnt == LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        state <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= ADD;
                end
                ADD: begin
`ifdef MULT_CTRL_SKIP_EN
                    // M=0 shifts in place, so the iteration finishes here
                    if (!M) begin
                        if (last_iter) begin
                            state <= DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= ADD;
                        end
                    end else begin
                        state <= SHIFT;
                    end
`else
                    state <= SHIFT;
`endif
                end
                SHIFT: begin
                    if (last_iter) begin
                        state <= DONE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= ADD;
                    end
                end
                DONE: begin
                    if (!Run) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Mealy outputs; reset forces every strobe low in the same cycle
    always_comb begin
        Clear_A  = 1'b0;
        Ld_A     = 1'b0;
        Ld_B     = 1'b0;
        Shift_En = 1'b0;
        Add      = 1'b0;
        Sub      = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        if (!Reset) begin
            case (state)
                IDLE: begin
                    if (!Run && ClearA_LoadB) begin
                        Clear_A = 1'b1;
                        Ld_A    = 1'b1;
                        Ld_B    = 1'b1;
                    end
                end
                START: begin
                    Busy    = 1'b1;
                    Clear_A = 1'b1;
                    Ld_A    = 1'b1;
                end
                ADD: begin
                    Busy = 1'b1;
                    if (M) begin
                        Ld_A = 1'b1;
                        Sub  = last_iter;
                        Add  = !last_iter;
                    end else begin
`ifdef MULT_CTRL_SKIP_EN
                        Shift_En = 1'b1;
`endif
                    end
                end
                SHIFT: begin
                    Busy     = 1'b1;
                    Shift_En = 1'b1;
                end
                DONE: begin
                    Busy = 1'b1;
                    Done = 1'b1;
                end
                default: begin
                    Busy = 1'b0;
                end
            endcase
        end
    end

endmodule
